vga_sync: RTL and testbench
===========================

# vga_sync

Raster timing generator for the 640x480 at 60 Hz display path. It divides the board clock into a pixel-enable strobe and advances horizontal and vertical counters on that strobe. It drives the monitor's active-low sync pins and publishes the current pixel coordinate `x`/`y`. Every glyph and sprite renderer compares that coordinate against its own `start_x`/`start_y` to decide `display`. This block is the single producer of the pixel coordinate bus consumed by all character blocks.

## Interface
- `CLK_DIV`, 4: board clocks per pixel (100 MHz → 25 MHz); must be ≥ 2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `clk`  input  1  board clock. Single clock domain; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `p_tick`  output  1  pixel-enable strobe, high for exactly one `clk` every `CLK_DIV` clocks.
- `hsync`  output  1  horizontal sync, active low.
- `vsync`  output  1  vertical sync, active low.
- `video_on`  output  1  high while (x, y) is inside the visible area.
- `frame_tick`  output  1  one-`clk` pulse marking the last pixel of a frame.
- `x`  output  10  current horizontal pixel count, range 0..H_TOTAL-1.
- `y`  output  10  current line count, range 0..V_TOTAL-1.

## Operation
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Divider
  - `div_cnt` counts 0..CLK_DIV-1 every `clk` and wraps to 0.
  - `p_tick` = (div_cnt == CLK_DIV-1), combinational from registered state.
- Horizontal counter
  - `h_cnt` advances only on clocks where `p_tick` = 1.
  - When `h_cnt` = H_TOTAL-1, it wraps to 0.
- Vertical counter
  - `v_cnt` advances only when `p_tick` = 1 and `h_cnt` = H_TOTAL-1.
  - When `v_cnt` = V_TOTAL-1 at that point, it wraps to 0.
- Derived outputs
  - `x` = `h_cnt`; `y` = `v_cnt`. Both are registered and never exceed 799 / 524.
  - `hsync` and `vsync` are registers loaded from the next-state counter values, so they change on the same edge as `x`/`y`.
  - `hsync` = 0 iff `h_cnt` ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` = 0 iff `v_cnt` ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
  - `video_on` = (`h_cnt` < H_DISPLAY) && (`v_cnt` < V_DISPLAY), combinational from the registered counters.
  - `frame_tick` = `p_tick` && (`h_cnt` == H_TOTAL-1) && (`v_cnt` == V_TOTAL-1).
- Counter widths: all comparisons are unsigned, 10-bit; `div_cnt` is sized for CLK_DIV-1.
- Reset
  - `reset` = 1 at any clock (mid-line or mid-frame included) forces `div_cnt` = 0, `h_cnt` = 0, `v_cnt` = 0, `hsync` = 1, `vsync` = 1 on that edge.
  - Reset has priority over `p_tick`.
- Output values during and after reset:
  - `x` = 0, `y` = 0.
  - `p_tick` = 0 (1 only when CLK_DIV = 1, which is disallowed).
  - `video_on` = 1.
  - `frame_tick` = 0.
  - `hsync` = 1, `vsync` = 1.

## Timing
- First `p_tick` occurs at the CLK_DIV-th clock after `reset` deasserts, i.e. with div_cnt = 3 (cycle 4 for CLK_DIV = 4).
- `x` increments on the edge that ends a `p_tick` cycle. Each (x, y) value is therefore held for exactly CLK_DIV clocks.
- Line period: H_TOTAL × CLK_DIV = 3200 clocks.
- Frame period: 3200 × 525 = 1 680 000 clocks.
- Line wrap: on one edge, `x` 799→0 and `y` increments; no intermediate (800, y) value appears.
- Frame wrap: on one edge, `x` 799→0 and `y` 524→0. `frame_tick` is high during the preceding `p_tick` cycle only.
- `hsync` falls on the same edge `x` becomes 656 and rises on the same edge `x` becomes 752.
- `vsync` falls on the same edge `y` becomes 490 and rises on the same edge `y` becomes 492.
- Latency from the (x, y) update to `video_on`: 0 clocks.

## Test plan
- Reset, then release and count 8 clocks → `p_tick` high on cycles 4 and 8 only; `x` = 0→1 after cycle 4, 1→2 after cycle 8; `hsync` = `vsync` = 1 throughout; `video_on` = 1.
- Run one full line → `hsync` low for exactly 96×4 = 384 clocks, starting with `x` = 656; `video_on` = 0 for `x` 640..799; after `x` = 799, next is `x` = 0, `y` = 1.
- Run to line 489 end → `vsync` falls with `y` = 490 at `x` = 0; rises at `y` = 492; `vsync` low for exactly 2×3200 = 6400 clocks.
- Run a full frame → exactly one `frame_tick` pulse (1 clock wide) at (799, 524); next state (0, 0); frame length 1 680 000 clocks; `x`/`y` never exceed 799/524.
- Assert `reset` for 1 clock at (700, 300) with `hsync` = 0 → next edge `x` = 0, `y` = 0, `hsync` = 1; timing then restarts identically to a power-on reset.
- Assert `reset` on a clock where `p_tick` = 1 at (799, 524) → counters go to 0; no `y` increment or other wrap artefact.

Source files
------------

// File: rtl/vga_sync_if.sv
// Pixel coordinate / sync bus published by vga_sync to the display path.
interface vga_sync_if;
   logic       p_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       frame_tick;
   logic [9:0] x;
   logic [9:0] y;

   modport master (output p_tick, hsync, vsync, video_on, frame_tick, x, y);
   modport slave  (input  p_tick, hsync, vsync, video_on, frame_tick, x, y);
endinterface

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-enable divider, h/v counters, active-low syncs.
// CLK_DIV must be at least 2 so that p_tick is low while reset is held.
module vga_sync #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   vga_sync_if.master o_vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic [9:0]       r_h_cnt;
   logic [9:0]       r_v_cnt;
   logic             r_hsync;
   logic             r_vsync;

   logic             w_p_tick;
   logic             w_h_end;
   logic             w_v_end;
   logic [9:0]       w_h_next;
   logic [9:0]       w_v_next;

   assign w_p_tick = (r_div_cnt == DIV_LAST);
   assign w_h_end  = (r_h_cnt == H_LAST);
   assign w_v_end  = (r_v_cnt == V_LAST);

   // Next raster position: x steps on each pixel strobe, y steps at end of line.
   always_comb begin
      w_h_next = r_h_cnt;
      w_v_next = r_v_cnt;
      if (w_p_tick) begin
         if (w_h_end) begin
            w_h_next = '0;
            w_v_next = w_v_end ? '0 : r_v_cnt + 10'd1;
         end else begin
            w_h_next = r_h_cnt + 10'd1;
         end
      end
   end

   // Pixel-enable divider, free-running modulo CLK_DIV.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
      end else if (w_p_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Counters and syncs; syncs decode the next position so they move with x/y.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else begin
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;
         r_hsync <= !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
         r_vsync <= !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
      end
   end

   assign o_vga.p_tick     = w_p_tick;
   assign o_vga.hsync      = r_hsync;
   assign o_vga.vsync      = r_vsync;
   assign o_vga.video_on   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign o_vga.frame_tick = w_p_tick && w_h_end && w_v_end;
   assign o_vga.x          = r_h_cnt;
   assign o_vga.y          = r_v_cnt;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance (line-level timing) and a shrunken
// instance (frame-level timing), both tracked clock by clock against a model
// that derives the raster position from the clock count since reset.
module tb_vga_sync;

   // Shrunken raster: 30 x 17 positions, 3 clocks per pixel.
   localparam int S_DIV = 3;
   localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 4;
   localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;

   typedef struct packed {
      logic       pt;
      logic       ft;
      logic       hs;
      logic       vs;
      logic       vo;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   typedef struct {
      logic rst;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_s = 1'b1;
   logic rst_d = 1'b1;

   vga_sync_if bus_s ();
   vga_sync_if bus_d ();

   vga_sync #(
      .CLK_DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
   ) dut_s (
      .clk   (clk),
      .reset (rst_s),
      .o_vga (bus_s)
   );

   vga_sync dut_d (
      .clk   (clk),
      .reset (rst_d),
      .o_vga (bus_d)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   t_s = 0;
   int   t_d = 0;
   obs_t q_s[$];
   obs_t q_d[$];
   obs_t cur_s, cur_d;
   logic prev_hs_d = 1'b1;
   logic prev_vs_s = 1'b1;
   logic mon_on = 1'b0;
   int   hs_low_d = 0, vs_low_s = 0, ft_s = 0, ft_d = 0;
   vec_t tbl[9];

   function automatic obs_t predict(input int t, input int cd,
                                    input int hd, input int hf, input int hsw, input int hb,
                                    input int vd, input int vf, input int vsw, input int vb);
      obs_t o;
      int   ht, vt, pix, h, v;
      ht  = hd + hf + hsw + hb;
      vt  = vd + vf + vsw + vb;
      pix = t / cd;
      h   = pix % ht;
      v   = (pix / ht) % vt;
      o.pt = ((t % cd) == cd - 1);
      o.x  = 10'(h);
      o.y  = 10'(v);
      o.hs = !((h >= hd + hf) && (h < hd + hf + hsw));
      o.vs = !((v >= vd + vf) && (v < vd + vf + vsw));
      o.vo = (h < hd) && (v < vd);
      o.ft = o.pt && (h == ht - 1) && (v == vt - 1);
      return o;
   endfunction

   function automatic obs_t mk(input logic pt, input int xv);
      obs_t o;
      o.pt = pt; o.ft = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.vo = 1'b1;
      o.x = 10'(xv); o.y = 10'd0;
      return o;
   endfunction

   task automatic chk(input string nm, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got pt=%b ft=%b hs=%b vs=%b vo=%b x=%0d y=%0d, want pt=%b ft=%b hs=%b vs=%b vo=%b x=%0d y=%0d",
                  nm, $time, act.pt, act.ft, act.hs, act.vs, act.vo, act.x, act.y,
                  exp.pt, exp.ft, exp.hs, exp.vs, exp.vo, exp.x, exp.y);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
      end
   endtask

   // One clock for both DUTs: predictions go into the queues with the stimulus,
   // and come out to be compared once the edge has produced the outputs.
   task automatic step(input logic rs, input logic rd);
      obs_t es, ed;
      rst_s = rs;
      rst_d = rd;
      t_s = rs ? 0 : t_s + 1;
      t_d = rd ? 0 : t_d + 1;
      q_s.push_back(predict(t_s, S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
      q_d.push_back(predict(t_d, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      @(posedge clk);
      #1;
      cur_s = {bus_s.p_tick, bus_s.frame_tick, bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.x, bus_s.y};
      cur_d = {bus_d.p_tick, bus_d.frame_tick, bus_d.hsync, bus_d.vsync, bus_d.video_on, bus_d.x, bus_d.y};
      es = q_s.pop_front();
      ed = q_d.pop_front();
      chk("small_model", cur_s, es);
      chk("full_model", cur_d, ed);
      if (mon_on) begin
         if (!cur_d.hs) hs_low_d++;
         if (!cur_s.vs) vs_low_s++;
         if (cur_s.ft) ft_s++;
         if (cur_d.ft) ft_d++;
         if (prev_hs_d && !cur_d.hs) chk_int("hsync_fall_x", int'(cur_d.x), 656);
         if (!prev_hs_d && cur_d.hs) chk_int("hsync_rise_x", int'(cur_d.x), 752);
         if (prev_vs_s && !cur_s.vs) chk_int("vsync_fall_y", int'(cur_s.y), 12);
         if (prev_vs_s && !cur_s.vs) chk_int("vsync_fall_x", int'(cur_s.x), 0);
      end
      prev_hs_d = cur_d.hs;
      prev_vs_s = cur_s.vs;
   endtask

   initial begin
      logic found;
      obs_t rst_exp;

      // Post-reset table for the full-size instance: strobe on cycles 4 and 8.
      tbl[0] = '{1'b1, mk(1'b0, 0)};
      tbl[1] = '{1'b0, mk(1'b0, 0)};
      tbl[2] = '{1'b0, mk(1'b0, 0)};
      tbl[3] = '{1'b0, mk(1'b1, 0)};
      tbl[4] = '{1'b0, mk(1'b0, 1)};
      tbl[5] = '{1'b0, mk(1'b0, 1)};
      tbl[6] = '{1'b0, mk(1'b0, 1)};
      tbl[7] = '{1'b0, mk(1'b1, 1)};
      tbl[8] = '{1'b0, mk(1'b0, 2)};
      rst_exp = mk(1'b0, 0);

      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].rst, tbl[i].rst);
         chk("reset_table", cur_d, tbl[i].exp);
      end

      // Free run: one full line of the big raster, two frames of the small one.
      mon_on = 1'b1;
      for (int i = 0; i < 3300; i++) begin
         step(1'b0, 1'b0);
         if (t_d == 3200) chk("line_wrap", cur_d, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1});
      end
      mon_on = 1'b0;
      chk_int("hsync_low_clks", hs_low_d, 384);
      chk_int("vsync_low_clks_small", vs_low_s, 2 * 180);
      chk_int("frame_ticks_small", ft_s, 2);
      chk_int("frame_ticks_full", ft_d, 0);

      // Mid-line reset of the full instance at x=700 with hsync low.
      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         step(1'b0, 1'b0);
         found = (cur_d.x == 10'd700) && !cur_d.hs;
      end
      chk_int("reach_x700", int'(found), 1);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, tbl[i].rst);
         chk("restart_table", cur_d, tbl[i].exp);
      end

      // Reset of the small instance on its frame_tick cycle at the last position.
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         step(1'b0, 1'b0);
         found = cur_s.ft;
      end
      chk_int("reach_frame_tick", int'(found), 1);
      chk_int("frame_tick_pos", int'(cur_s.x) * 1000 + int'(cur_s.y), 29 * 1000 + 16);
      step(1'b1, 1'b0);
      chk("reset_on_ptick", cur_s, rst_exp);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
